bcd_conv_arbiter: RTL and testbench

//  Shares a single binary-to-BCD converter (4-digit, 0..9999) between N_REQ requesters.

---
 rtl/bcd_conv_arbiter_pkg.sv | 16 +
 rtl/bcd_conv_arbiter_if.sv | 33 +++
 rtl/bcd_conv_arbiter_rr_arbiter.sv | 34 +++
 rtl/bcd_conv_arbiter.sv | 122 ++++++++++++
 tb/tb_bcd_conv_arbiter.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_conv_arbiter_pkg.sv
// Shared types and constants for the BCD converter arbiter.
//   state_t    : arbiter FSM states
//   BCD_ERR    : result reported when the converter watchdog fires
//   clamp_bin(): saturate an operand to a limit
package bcd_conv_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  localparam logic [15:0] BCD_ERR     = 16'hFFFF;
  localparam int          BCD_MAX_VAL = 9999;

  function automatic logic [31:0] clamp_bin(input logic [31:0] v, input logic [31:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/bcd_conv_arbiter_if.sv
// Requester + converter bus of the BCD converter arbiter.
//   i_req/i_bin          : per-requester request level and operand
//   o_gnt/o_done/o_bcd   : grant, one-cycle completion, result digits
//   o_ovf/o_err/o_busy   : clamp flag, watchdog flag, not-idle status
//   o_cv_*/i_cv_*        : shared converter start/operand and done/result
// slave = arbiter side, master = requesters/converter side.
interface bcd_conv_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 14
);
  logic [N_REQ-1:0]       i_req;
  logic [N_REQ*WIDTH-1:0] i_bin;
  logic [N_REQ-1:0]       o_gnt;
  logic [N_REQ-1:0]       o_done;
  logic [15:0]            o_bcd;
  logic                   o_ovf;
  logic                   o_err;
  logic                   o_busy;
  logic                   o_cv_start;
  logic [WIDTH-1:0]       o_cv_bin;
  logic                   i_cv_done;
  logic [15:0]            i_cv_bcd;

  modport slave (
    input  i_req, i_bin, i_cv_done, i_cv_bcd,
    output o_gnt, o_done, o_bcd, o_ovf, o_err, o_busy, o_cv_start, o_cv_bin
  );

  modport master (
    output i_req, i_bin, i_cv_done, i_cv_bcd,
    input  o_gnt, o_done, o_bcd, o_ovf, o_err, o_busy, o_cv_start, o_cv_bin
  );
endinterface

// File: rtl/bcd_conv_arbiter_rr_arbiter.sv
// Combinational round-robin pick.
//   req : request vector
//   ptr : highest-priority index this round
//   gnt : one-hot winner, idx : winner index, any : some request present
module bcd_conv_arbiter_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx,
  output logic             any
);

  int k;

  // Scan cyclically from ptr; first set bit wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    k   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      k = (int'(ptr) + i) % N_REQ;
      if (!any && req[k]) begin
        any    = 1'b1;
        idx    = IW'(k);
        gnt[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Shares one 4-digit binary-to-BCD converter among N_REQ requesters.
//   i_clk, i_rst_n : clock, async active-low reset
//   bus            : requester/converter bus (bcd_conv_arbiter_if.slave)
// Flow: IDLE picks a winner round-robin and latches its clamped operand,
// START pulses the converter, WAIT collects the result or aborts on the
// watchdog, RESP pulses o_done to the winner and advances the pointer.
module bcd_conv_arbiter
  import bcd_conv_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 14,
  parameter int MAX_VAL = BCD_MAX_VAL,
  parameter int TIMEOUT = 64
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  bcd_conv_arbiter_if.slave  bus
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT);

  state_t           state, nxt;
  logic [IW-1:0]    ptr, idx_q, arb_idx;
  logic [N_REQ-1:0] arb_gnt, gnt_q;
  logic             arb_any;
  logic [WIDTH-1:0] bin_sel, bin_q;
  logic             ovf_q, err_q;
  logic [CW-1:0]    wd_cnt;
  logic [15:0]      bcd_q;
  logic             wd_exp;

  bcd_conv_arbiter_rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
    .req (bus.i_req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign bin_sel      = bus.i_bin[arb_idx*WIDTH +: WIDTH];
  assign wd_exp       = (wd_cnt == CW'(TIMEOUT-1));
  assign bus.o_bcd    = bcd_q;
  assign bus.o_cv_bin = bin_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt            = state;
    bus.o_cv_start = 1'b0;
    bus.o_gnt      = '0;
    bus.o_done     = '0;
    bus.o_ovf      = 1'b0;
    bus.o_err      = 1'b0;
    bus.o_busy     = 1'b1;
    unique case (state)
      IDLE: begin
        bus.o_busy = 1'b0;
        if (arb_any) nxt = START;
      end
      START: begin
        bus.o_cv_start = 1'b1;
        bus.o_gnt      = gnt_q;
        nxt            = WAIT;
      end
      WAIT: begin
        bus.o_gnt = gnt_q;
        if (bus.i_cv_done || wd_exp) nxt = RESP;
      end
      RESP: begin
        bus.o_gnt  = gnt_q;
        bus.o_done = gnt_q;
        bus.o_ovf  = ovf_q;
        bus.o_err  = err_q;
        nxt        = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Datapath: winner/operand latch, watchdog, result register, rr pointer.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr    <= '0;
      idx_q  <= '0;
      gnt_q  <= '0;
      bin_q  <= '0;
      ovf_q  <= 1'b0;
      err_q  <= 1'b0;
      wd_cnt <= '0;
      bcd_q  <= '0;
    end else begin
      unique case (state)
        IDLE: if (arb_any) begin
          idx_q <= arb_idx;
          gnt_q <= arb_gnt;
          bin_q <= WIDTH'(clamp_bin(32'(bin_sel), 32'(MAX_VAL)));
          ovf_q <= (32'(bin_sel) > 32'(MAX_VAL));
          err_q <= 1'b0;
        end
        START: wd_cnt <= '0;
        WAIT: begin
          // A done arriving on the last watchdog cycle still counts as success.
          if (bus.i_cv_done) begin
            bcd_q <= bus.i_cv_bcd;
          end else if (wd_exp) begin
            bcd_q <= BCD_ERR;
            err_q <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        RESP: ptr <= (idx_q == IW'(N_REQ-1)) ? '0 : idx_q + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
module tb_bcd_conv_arbiter;

  localparam int N = 4;
  localparam int W = 14;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b1;
  always #5 i_clk = ~i_clk;

  bcd_conv_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus();

  bcd_conv_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_VAL(9999), .TIMEOUT(64)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // converter model
  int          cv_lat  = 17;
  logic        cv_hang = 1'b0;
  logic        cv_spur = 1'b0;
  logic        cv_done;
  logic [15:0] cv_bcd;
  int          cv_cnt;
  logic [13:0] cv_op;

  assign bus.i_cv_done = cv_done | cv_spur;
  assign bus.i_cv_bcd  = cv_bcd;

  function automatic logic [15:0] gold(input int v);
    int c;
    c = (v > 9999) ? 9999 : v;
    return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cv_done <= 1'b0;
      cv_cnt  <= 0;
      cv_bcd  <= '0;
      cv_op   <= '0;
    end else begin
      cv_done <= 1'b0;
      if (bus.o_cv_start) begin
        cv_cnt <= cv_lat;
        cv_op  <= bus.o_cv_bin;
      end else if (cv_cnt != 0) begin
        cv_cnt <= cv_cnt - 1;
        if (cv_cnt == 1 && !cv_hang) begin
          cv_done <= 1'b1;
          cv_bcd  <= gold(int'(cv_op));
        end
      end
    end
  end

  logic        ok;
  int          cyc, scyc;
  logic [13:0] bseen;

  task automatic set_bin(input int k, input int v);
    bus.i_bin[k*W +: W] = W'(v);
  endtask

  // Waits for an o_done pulse; records cycles to it, start cycle and operand.
  task automatic wait_done(input int limit, output logic okk, output int c,
                           output int sc, output logic [13:0] bs);
    okk = 1'b0; c = 0; sc = -1; bs = '0;
    while (!okk && c < limit) begin
      @(negedge i_clk);
      c++;
      if (bus.o_cv_start) begin sc = c; bs = bus.o_cv_bin; end
      if (bus.o_done != '0) okk = 1'b1;
    end
  endtask

  task automatic test_reset;
    #1 i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    n_chk++;
    if ({bus.o_gnt, bus.o_done, bus.o_bcd, bus.o_ovf, bus.o_err, bus.o_busy, bus.o_cv_start, bus.o_cv_bin} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got bcd=%h busy=%b gnt=%b, want all zero", bus.o_bcd, bus.o_busy, bus.o_gnt);
    end
    i_rst_n = 1'b1;
    @(negedge i_clk);
    n_chk++;
    if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: busy=%b want 0", bus.o_busy); end
  endtask

  task automatic test_single;
    cv_lat = 17;
    set_bin(0, 1234);
    bus.i_req = 4'b0001;
    wait_done(100, ok, cyc, scyc, bseen);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL single_timeout: no o_done in 100 cycles"); end
    n_chk++; if (scyc !== 1) begin n_fail++; $display("FAIL single_start_lat: got %0d want 1", scyc); end
    n_chk++; if (bseen !== 14'd1234) begin n_fail++; $display("FAIL single_cv_bin: got %0d want 1234", bseen); end
    n_chk++; if (cyc !== 20) begin n_fail++; $display("FAIL single_done_lat: got %0d want 20", cyc); end
    n_chk++; if (bus.o_done !== 4'b0001) begin n_fail++; $display("FAIL single_done: got %b want 0001", bus.o_done); end
    n_chk++; if (bus.o_gnt !== 4'b0001) begin n_fail++; $display("FAIL single_gnt: got %b want 0001", bus.o_gnt); end
    n_chk++; if (bus.o_bcd !== 16'h1234) begin n_fail++; $display("FAIL single_bcd: got %h want 1234", bus.o_bcd); end
    n_chk++; if ({bus.o_ovf, bus.o_err} !== 2'b00) begin n_fail++; $display("FAIL single_flags: got %b want 00", {bus.o_ovf, bus.o_err}); end
    bus.i_req = '0;
    @(negedge i_clk);
    n_chk++;
    if ({bus.o_done, bus.o_busy, bus.o_bcd} !== {4'b0000, 1'b0, 16'h1234}) begin
      n_fail++; $display("FAIL single_hold: done=%b busy=%b bcd=%h want 0000 0 1234", bus.o_done, bus.o_busy, bus.o_bcd);
    end
  endtask

  task automatic test_reset_mid_wait;
    logic bad;
    cv_hang = 1'b1;
    set_bin(0, 5);
    bus.i_req = 4'b0001;
    repeat (6) @(negedge i_clk);
    n_chk++;
    if ({bus.o_busy, bus.o_gnt} !== 5'b1_0001) begin n_fail++; $display("FAIL rst_wait_pre: busy=%b gnt=%b want 1 0001", bus.o_busy, bus.o_gnt); end
    i_rst_n = 1'b0;
    #1;
    n_chk++;
    if ({bus.o_gnt, bus.o_done, bus.o_bcd, bus.o_ovf, bus.o_err, bus.o_busy, bus.o_cv_start, bus.o_cv_bin} !== '0) begin
      n_fail++; $display("FAIL rst_wait_zero: bcd=%h busy=%b cv_bin=%0d want all zero", bus.o_bcd, bus.o_busy, bus.o_cv_bin);
    end
    bus.i_req = '0;
    cv_hang   = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    bad = 1'b0;
    repeat (4) begin
      @(negedge i_clk);
      if (bus.o_busy || bus.o_done != '0) bad = 1'b1;
    end
    n_chk++; if (bad !== 1'b0) begin n_fail++; $display("FAIL rst_wait_after: activity=%b want 0", bad); end
  endtask

  task automatic test_round_robin;
    logic [15:0] rr_bcd [4];
    int e;
    rr_bcd = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    cv_lat = 3;
    set_bin(0, 11); set_bin(1, 22); set_bin(2, 33); set_bin(3, 44);
    bus.i_req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      e = n % 4;
      wait_done(50, ok, cyc, scyc, bseen);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL rr_timeout[%0d]: no o_done", n); end
      n_chk++; if (bus.o_done !== 4'(1 << e)) begin n_fail++; $display("FAIL rr_done[%0d]: got %b want %b", n, bus.o_done, 4'(1 << e)); end
      n_chk++; if (bus.o_bcd !== rr_bcd[e]) begin n_fail++; $display("FAIL rr_bcd[%0d]: got %h want %h", n, bus.o_bcd, rr_bcd[e]); end
      if (n > 0) begin
        n_chk++; if (scyc !== 2) begin n_fail++; $display("FAIL rr_b2b[%0d]: start at %0d want 2", n, scyc); end
      end
    end
    bus.i_req = '0;
    @(negedge i_clk);
  endtask

  task automatic test_saturation;
    int          vin  [4];
    logic [13:0] vcv  [4];
    logic [15:0] vbcd [4];
    logic        vovf [4];
    vin  = '{16383, 9999, 10000, 0};
    vcv  = '{14'd9999, 14'd9999, 14'd9999, 14'd0};
    vbcd = '{16'h9999, 16'h9999, 16'h9999, 16'h0000};
    vovf = '{1'b1, 1'b0, 1'b1, 1'b0};
    cv_lat = 5;
    for (int t = 0; t < 4; t++) begin
      set_bin(1, vin[t]);
      bus.i_req = 4'b0010;
      wait_done(50, ok, cyc, scyc, bseen);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL sat_timeout[%0d]: no o_done", vin[t]); end
      n_chk++; if (bseen !== vcv[t]) begin n_fail++; $display("FAIL sat_cv_bin[%0d]: got %0d want %0d", vin[t], bseen, vcv[t]); end
      n_chk++; if (bus.o_bcd !== vbcd[t]) begin n_fail++; $display("FAIL sat_bcd[%0d]: got %h want %h", vin[t], bus.o_bcd, vbcd[t]); end
      n_chk++; if ({bus.o_ovf, bus.o_err} !== {vovf[t], 1'b0}) begin n_fail++; $display("FAIL sat_flags[%0d]: got %b want %b0", vin[t], {bus.o_ovf, bus.o_err}, vovf[t]); end
      bus.i_req = '0;
      @(negedge i_clk);
    end
  endtask

  task automatic test_watchdog;
    cv_hang = 1'b1;
    set_bin(2, 77);
    bus.i_req = 4'b0100;
    wait_done(200, ok, cyc, scyc, bseen);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL wd_timeout: no o_done in 200 cycles"); end
    n_chk++; if (cyc !== 66) begin n_fail++; $display("FAIL wd_lat: got %0d want 66", cyc); end
    n_chk++; if (bus.o_done !== 4'b0100) begin n_fail++; $display("FAIL wd_done: got %b want 0100", bus.o_done); end
    n_chk++; if (bus.o_bcd !== 16'hFFFF) begin n_fail++; $display("FAIL wd_bcd: got %h want ffff", bus.o_bcd); end
    n_chk++; if ({bus.o_err, bus.o_ovf} !== 2'b10) begin n_fail++; $display("FAIL wd_flags: got %b want 10", {bus.o_err, bus.o_ovf}); end
    bus.i_req = '0;
    cv_hang   = 1'b0;
    @(negedge i_clk);
    n_chk++; if (bus.o_err !== 1'b0) begin n_fail++; $display("FAIL wd_err_pulse: got %b want 0", bus.o_err); end
    cv_lat = 3;
    set_bin(1, 42);
    bus.i_req = 4'b0010;
    wait_done(50, ok, cyc, scyc, bseen);
    n_chk++;
    if (!ok || bus.o_done !== 4'b0010 || bus.o_bcd !== 16'h0042 || bus.o_err !== 1'b0) begin
      n_fail++; $display("FAIL wd_next: ok=%b done=%b bcd=%h err=%b want 1 0010 0042 0", ok, bus.o_done, bus.o_bcd, bus.o_err);
    end
    bus.i_req = '0;
    @(negedge i_clk);
  endtask

  task automatic test_done_vs_timeout;
    cv_lat = 63;
    set_bin(3, 321);
    bus.i_req = 4'b1000;
    wait_done(200, ok, cyc, scyc, bseen);
    n_chk++; if (cyc !== 66) begin n_fail++; $display("FAIL tie_lat: got %0d want 66", cyc); end
    n_chk++;
    if (!ok || bus.o_done !== 4'b1000 || bus.o_bcd !== 16'h0321 || bus.o_err !== 1'b0) begin
      n_fail++; $display("FAIL tie_result: ok=%b done=%b bcd=%h err=%b want 1 1000 0321 0", ok, bus.o_done, bus.o_bcd, bus.o_err);
    end
    bus.i_req = '0;
    @(negedge i_clk);
  endtask

  task automatic test_spurious_done;
    cv_spur = 1'b1;
    @(negedge i_clk);
    cv_spur = 1'b0;
    n_chk++;
    if ({bus.o_busy, bus.o_done, bus.o_bcd} !== {1'b0, 4'b0000, 16'h0321}) begin
      n_fail++; $display("FAIL spur_idle: busy=%b done=%b bcd=%h want 0 0000 0321", bus.o_busy, bus.o_done, bus.o_bcd);
    end
  endtask

  task automatic test_withdraw;
    int extra;
    cv_lat = 10;
    set_bin(0, 8);
    bus.i_req = 4'b0001;
    @(negedge i_clk);
    set_bin(3, 3);
    bus.i_req = 4'b1001;
    repeat (3) @(negedge i_clk);
    bus.i_req = 4'b0001;
    wait_done(50, ok, cyc, scyc, bseen);
    n_chk++;
    if (!ok || bus.o_done !== 4'b0001 || bus.o_bcd !== 16'h0008) begin
      n_fail++; $display("FAIL wd_owner: ok=%b done=%b bcd=%h want 1 0001 0008", ok, bus.o_done, bus.o_bcd);
    end
    bus.i_req = '0;
    extra = 0;
    repeat (30) begin
      @(negedge i_clk);
      if (bus.o_busy || bus.o_done != '0) extra++;
    end
    n_chk++; if (extra !== 0) begin n_fail++; $display("FAIL withdrawn: %0d active cycles want 0", extra); end
  endtask

  task automatic test_sweep;
    int bad;
    bad = 0;
    cv_lat = 1;
    for (int v = 0; v <= 9999; v++) begin
      set_bin(2, v);
      bus.i_req = 4'b0100;
      wait_done(20, ok, cyc, scyc, bseen);
      n_chk++;
      if (!ok || bus.o_done !== 4'b0100 || bus.o_bcd !== gold(v) || bus.o_ovf !== 1'b0) begin
        n_fail++; bad++;
        if (bad <= 10) $display("FAIL sweep[%0d]: ok=%b done=%b bcd=%h ovf=%b want 1 0100 %h 0", v, ok, bus.o_done, bus.o_bcd, bus.o_ovf, gold(v));
      end
      bus.i_req = '0;
      @(negedge i_clk);
    end
  endtask

  initial begin
    bus.i_req = '0;
    bus.i_bin = '0;
    test_reset();
    test_single();
    test_reset_mid_wait();
    test_round_robin();
    test_saturation();
    test_watchdog();
    test_done_vs_timeout();
    test_spurious_done();
    test_withdraw();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
